// File: rtl/rgb_reader_pkg.sv
// rgb_reader_pkg: shared FSM state type and luma constants for the RGB stream reader
package rgb_reader_pkg;
  typedef enum logic [2:0] {IDLE, RD0, RD1, RD2, CAP, HOLD} state_t;
  localparam logic [7:0] LUMA_R = 8'd77;
  localparam logic [7:0] LUMA_G = 8'd150;
  localparam logic [7:0] LUMA_B = 8'd29;
  localparam int LUMA_SHIFT = 8;
endpackage

// File: rtl/rgb_luma.sv
// rgb_luma: combinational weighted luma (77R + 150G + 29B) >> 8 on a 16-bit sum
module rgb_luma
  import rgb_reader_pkg::*;
(
  input  logic [7:0] i_red,
  input  logic [7:0] i_green,
  input  logic [7:0] i_blue,
  output logic [7:0] o_gray
);
  logic [15:0] w_sum;
  assign w_sum = {8'd0, LUMA_R} * {8'd0, i_red} + {8'd0, LUMA_G} * {8'd0, i_green}
               + {8'd0, LUMA_B} * {8'd0, i_blue};
  assign o_gray = 8'(w_sum >> LUMA_SHIFT);
endmodule

// File: rtl/rgb_stream_reader.sv
// rgb_stream_reader: reads packed R,G,B bytes from memory and streams one pixel per valid/ready handshake
// Optional gray_o output and luma logic when RGB_READER_GRAY_EN is defined.
module rgb_stream_reader
  import rgb_reader_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int NUM_PIXELS = 17066
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  output logic              mem_rd_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [7:0]        mem_data_i,
  output logic [7:0]        red_o,
  output logic [7:0]        green_o,
  output logic [7:0]        blue_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              busy_o,
  output logic              done_o
`ifdef RGB_READER_GRAY_EN
  ,
  output logic [7:0]        gray_o
`endif
);
  localparam int CW = NUM_PIXELS > 0 ? $clog2(NUM_PIXELS + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'(NUM_PIXELS > 0 ? NUM_PIXELS - 1 : 0);
  state_t r_state, w_next;
  logic [ADDR_W-1:0] r_addr, w_addr;
  logic [CW-1:0] r_cnt;
  logic [7:0] r_red_stg, r_grn_stg;
  logic w_xfer, w_last;
  assign w_xfer = valid_o && ready_i;
  assign w_last = w_xfer && r_cnt == LAST;
  assign w_addr = (r_state == IDLE && start_i) ? base_addr_i :
                  (r_state == HOLD && w_xfer) ? r_addr + ADDR_W'(3) : r_addr;
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    w_next = (start_i && NUM_PIXELS != 0) ? RD0 : IDLE;
      RD0:     w_next = RD1;
      RD1:     w_next = RD2;
      RD2:     w_next = CAP;
      CAP:     w_next = HOLD;
      HOLD:    w_next = !w_xfer ? HOLD : w_last ? IDLE : RD0;
      default: w_next = IDLE;
    endcase
  end
`ifdef RGB_READER_GRAY_EN
  logic [7:0] w_gray;
  rgb_luma u_luma (.i_red(r_red_stg), .i_green(r_grn_stg), .i_blue(mem_data_i), .o_gray(w_gray));
  always_ff @(posedge clk)
    if (rst) gray_o <= '0;
    else if (r_state == CAP) gray_o <= w_gray;
`endif
  // Output strobes are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_cnt      <= '0;
      r_red_stg  <= '0;
      r_grn_stg  <= '0;
      red_o      <= '0;
      green_o    <= '0;
      blue_o     <= '0;
      valid_o    <= 1'b0;
      mem_rd_o   <= 1'b0;
      mem_addr_o <= '0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_addr     <= w_addr;
      r_cnt      <= r_state == IDLE ? '0 : w_xfer ? r_cnt + CW'(1) : r_cnt;
      r_red_stg  <= r_state == RD1 ? mem_data_i : r_red_stg;
      r_grn_stg  <= r_state == RD2 ? mem_data_i : r_grn_stg;
      red_o      <= r_state == CAP ? r_red_stg : red_o;
      green_o    <= r_state == CAP ? r_grn_stg : green_o;
      blue_o     <= r_state == CAP ? mem_data_i : blue_o;
      valid_o    <= r_state == CAP ? 1'b1 : w_xfer ? 1'b0 : valid_o;
      mem_rd_o   <= w_next == RD0 || w_next == RD1 || w_next == RD2;
      mem_addr_o <= w_next == RD1 ? w_addr + ADDR_W'(1) : w_next == RD2 ? w_addr + ADDR_W'(2) : w_addr;
      busy_o     <= w_next != IDLE;
      done_o     <= (r_state == IDLE && start_i && NUM_PIXELS == 0) || w_last;
    end
  end
endmodule
